// File: rtl/layer1_sequencer.sv
// layer1_sequencer: time-multiplexes one neuron_layer1 MAC/ReLU over all layer-1 neurons.
// Optional LAYER1_ARGMAX_EN adds a running argmax over the frame (pred_valid/pred_idx).
module layer1_sequencer #(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 32,
    parameter int DW        = 32,
    parameter int IAW       = $clog2(N_INPUTS),
    parameter int WAW       = $clog2(N_INPUTS*N_NEURONS),
    parameter int NAW       = $clog2(N_NEURONS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [IAW-1:0] in_addr,
    input  logic [DW-1:0]  in_data,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_data,
    output logic [NAW-1:0] b_addr,
    input  logic [DW-1:0]  b_data,
    output logic           n_bias_load,
    output logic           n_valid,
    output logic [DW-1:0]  n_value,
    output logic [DW-1:0]  n_weight,
    input  logic [DW-1:0]  n_relu,
    output logic           res_valid,
    output logic [NAW-1:0] res_idx,
    output logic [DW-1:0]  res_data
`ifdef LAYER1_ARGMAX_EN
    ,
    output logic           pred_valid,
    output logic [NAW-1:0] pred_idx
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        CAPTURE
    } state_t;

    localparam logic [IAW-1:0] I_LAST = IAW'(N_INPUTS - 1);
    localparam logic [NAW-1:0] J_LAST = NAW'(N_NEURONS - 1);
    localparam logic [WAW-1:0] W_STEP = WAW'(N_INPUTS);

    state_t         state;
    state_t         state_nx;
    logic [IAW-1:0] i_cnt;
    logic [NAW-1:0] j_cnt;
    logic [WAW-1:0] w_off;
    logic           drain_cnt;
    logic           last_j;

    assign last_j = (j_cnt == J_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and address generation from registered state.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        in_addr  = '0;
        w_addr   = '0;
        b_addr   = '0;
        unique case (state)
            IDLE:    if (start) state_nx = BIAS;
            BIAS: begin
                b_addr   = j_cnt;
                state_nx = MAC;
            end
            MAC: begin
                in_addr = i_cnt;
                w_addr  = w_off + WAW'(i_cnt);
                if (i_cnt == I_LAST) state_nx = DRAIN;
            end
            DRAIN:   if (drain_cnt) state_nx = CAPTURE;
            CAPTURE: state_nx = last_j ? IDLE : BIAS;
            default: state_nx = IDLE;
        endcase
    end

    // Input, drain and neuron counters; w_off tracks j*N_INPUTS.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            w_off     <= '0;
            drain_cnt <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    w_off <= '0;
                end
                BIAS: begin
                    i_cnt     <= '0;
                    drain_cnt <= 1'b0;
                end
                MAC:   i_cnt     <= i_cnt + IAW'(1);
                DRAIN: drain_cnt <= 1'b1;
                CAPTURE: if (!last_j) begin
                    j_cnt <= j_cnt + NAW'(1);
                    w_off <= w_off + W_STEP;
                end
                default: ;
            endcase
        end
    end

    // Strobes delayed one cycle to line up with synchronous memory data.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_bias_load <= 1'b0;
            n_valid     <= 1'b0;
            res_valid   <= 1'b0;
            done        <= 1'b0;
            res_idx     <= '0;
            res_data    <= '0;
        end else begin
            n_bias_load <= (state == BIAS);
            n_valid     <= (state == MAC);
            res_valid   <= (state == CAPTURE);
            done        <= (state == CAPTURE) && last_j;
            if (state == CAPTURE) begin
                res_idx  <= j_cnt;
                res_data <= n_relu;
            end
        end
    end

    assign n_value  = n_bias_load ? b_data : in_data;
    assign n_weight = w_data;

`ifdef LAYER1_ARGMAX_EN
    logic [DW-1:0]  best_val;
    logic [NAW-1:0] best_idx;
    logic           take;

    // Neuron 0 seeds the maximum; strict compare keeps the lowest index on ties.
    assign take = (j_cnt == '0) || ($signed(n_relu) > $signed(best_val));

    // Running maximum over captured results, published with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_val   <= '0;
            best_idx   <= '0;
            pred_valid <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= (state == CAPTURE) && last_j;
            if (state == IDLE && start) begin
                best_val <= '0;
                best_idx <= '0;
            end else if (state == CAPTURE) begin
                if (take) begin
                    best_val <= n_relu;
                    best_idx <= j_cnt;
                end
                if (last_j) pred_idx <= take ? j_cnt : best_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer1_sequencer.sv
// tb_layer1_sequencer: randomized self-checking bench with a timeline reference model.
// Build with LAYER1_ARGMAX_EN defined to also exercise the argmax outputs.
module tb_layer1_sequencer;

    localparam int NI  = 4;
    localparam int NN  = 3;
    localparam int P   = NI + 4;
    localparam int DW  = 32;
    localparam int IAW = $clog2(NI);
    localparam int WAW = $clog2(NI*NN);
    localparam int NAW = $clog2(NN);
    localparam int ML  = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic [IAW-1:0] in_addr;
    logic [DW-1:0]  in_data;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  w_data;
    logic [NAW-1:0] b_addr;
    logic [DW-1:0]  b_data;
    logic           n_bias_load;
    logic           n_valid;
    logic [DW-1:0]  n_value;
    logic [DW-1:0]  n_weight;
    logic [DW-1:0]  n_relu;
    logic           res_valid;
    logic [NAW-1:0] res_idx;
    logic [DW-1:0]  res_data;
`ifdef LAYER1_ARGMAX_EN
    logic           pred_valid;
    logic [NAW-1:0] pred_idx;
`endif

    layer1_sequencer #(
        .N_INPUTS (NI),
        .N_NEURONS(NN),
        .DW       (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .n_bias_load(n_bias_load),
        .n_valid    (n_valid),
        .n_value    (n_value),
        .n_weight   (n_weight),
        .n_relu     (n_relu),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_data   (res_data)
`ifdef LAYER1_ARGMAX_EN
        ,
        .pred_valid (pred_valid),
        .pred_idx   (pred_idx)
`endif
    );

    always #5 clk = ~clk;

    int in_mem[NI];
    int w_mem[NI*NN];
    int b_mem[NN];

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= (int'(w_addr) < NI*NN) ? w_mem[w_addr] : 0;
        b_data  <= (int'(b_addr) < NN) ? b_mem[b_addr] : 0;
    end

    // Neuron stand-in: product stage, then accumulate; ReLU on the accumulator.
    int   acc;
    int   prod;
    logic v2;
    always @(posedge clk) begin
        if (rst) begin
            acc  <= 0;
            prod <= 0;
            v2   <= 1'b0;
        end else begin
            v2   <= n_valid;
            prod <= int'((longint'($signed(n_value)) *
                          longint'($signed(n_weight))) >>> 16);
            if (n_bias_load) acc <= $signed(n_value);
            else if (v2)     acc <= acc + prod;
        end
    end
    assign n_relu = (acc < 0) ? 32'd0 : acc;

    int n_chk;
    int n_pass;

    bit st_pat[ML];
    bit rs_pat[ML];

    logic s_rv[ML], s_dn[ML], s_bz[ML], s_bl[ML], s_vl[ML], s_pv[ML];
    int   s_ri[ML], s_rd[ML], s_ia[ML], s_wa[ML], s_ba[ML], s_pi[ML];
    bit   e_rv[ML], e_dn[ML], e_bz[ML], e_bl[ML], e_vl[ML];
    int   e_ri[ML], e_rd[ML], e_ia[ML], e_wa[ML], e_ba[ML];

    function automatic int ref_out(input int k);
        int a;
        a = b_mem[k];
        for (int i = 0; i < NI; i++)
            a = a + int'((longint'(in_mem[i]) *
                          longint'(w_mem[k*NI+i])) >>> 16);
        return (a < 0) ? 0 : a;
    endfunction

    function automatic int ref_argmax();
        int bi;
        bi = 0;
        for (int k = 1; k < NN; k++)
            if (ref_out(k) > ref_out(bi)) bi = k;
        return bi;
    endfunction

    task automatic clear_exp_from(input int t0);
        for (int t = t0; t < ML; t++) begin
            e_rv[t] = 0; e_dn[t] = 0; e_bz[t] = 0;
            e_bl[t] = 0; e_vl[t] = 0; e_ri[t] = 0;
            e_rd[t] = 0; e_ia[t] = 0; e_wa[t] = 0;
            e_ba[t] = 0;
        end
    endtask

    task automatic sched(input int s);
        for (int k = 0; k < NN; k++) begin
            int b;
            int r;
            b = s + 1 + k*P;
            e_ba[b]     = k;
            e_bl[b+1]   = 1;
            for (int p = 0; p < NI; p++) begin
                e_ia[b+1+p] = p;
                e_wa[b+1+p] = k*NI + p;
                e_vl[b+2+p] = 1;
            end
            r = s + (k+1)*P + 1;
            e_rv[r] = 1;
            e_ri[r] = k;
            e_rd[r] = ref_out(k);
        end
        e_dn[s + NN*P + 1] = 1;
        for (int t = s + 1; t <= s + NN*P; t++) e_bz[t] = 1;
    endtask

    task automatic build_exp(input int n);
        int free_at;
        int hi;
        int hd;
        clear_exp_from(0);
        free_at = 0;
        for (int t = 0; t < n; t++) begin
            if (rs_pat[t]) begin
                clear_exp_from(t + 1);
                free_at = t + 1;
            end else if (st_pat[t] && t >= free_at) begin
                sched(t);
                free_at = t + NN*P + 1;
            end
        end
        hi = 0;
        hd = 0;
        for (int t = 0; t < ML; t++) begin
            if (t > 0 && rs_pat[t-1]) begin
                hi = 0;
                hd = 0;
            end
            if (e_rv[t]) begin
                hi = e_ri[t];
                hd = e_rd[t];
            end
            e_ri[t] = hi;
            e_rd[t] = hd;
        end
    endtask

    task automatic clear_pats();
        for (int t = 0; t < ML; t++) begin
            st_pat[t] = 0;
            rs_pat[t] = 0;
        end
    endtask

    task automatic fill_const();
        for (int i = 0; i < NI; i++) in_mem[i] = 32'h20000;
        for (int i = 0; i < NI*NN; i++) w_mem[i] = 32'h10000;
        for (int k = 0; k < NN; k++) b_mem[k] = 32'h8000;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NI; i++)
            in_mem[i] = int'($urandom_range(0, 524288)) - 262144;
        for (int i = 0; i < NI*NN; i++)
            w_mem[i] = int'($urandom_range(0, 262144)) - 131072;
        for (int k = 0; k < NN; k++)
            b_mem[k] = int'($urandom_range(0, 131072)) - 65536;
    endtask

    task automatic run(input int n);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            rst   = rs_pat[t];
            start = st_pat[t];
            #1;
            s_rv[t] = res_valid;
            s_dn[t] = done;
            s_bz[t] = busy;
            s_bl[t] = n_bias_load;
            s_vl[t] = n_valid;
            s_ri[t] = int'(res_idx);
            s_rd[t] = res_data;
            s_ia[t] = int'(in_addr);
            s_wa[t] = int'(w_addr);
            s_ba[t] = int'(b_addr);
`ifdef LAYER1_ARGMAX_EN
            s_pv[t] = pred_valid;
            s_pi[t] = int'(pred_idx);
`else
            s_pv[t] = 1'b0;
            s_pi[t] = 0;
`endif
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, done, res_valid, n_bias_load, n_valid} !== 5'b0)
            $display("FAIL reset_strobes got %b exp 00000",
                     {busy, done, res_valid, n_bias_load, n_valid});
        else n_pass++;
        n_chk++;
        if (res_idx !== '0 || res_data !== '0)
            $display("FAIL reset_res got idx %0d data %h exp 0 0",
                     res_idx, res_data);
        else n_pass++;
        n_chk++;
        if ({in_addr, w_addr, b_addr} !== '0)
            $display("FAIL reset_addr got %h %h %h exp 0 0 0",
                     in_addr, w_addr, b_addr);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        fill_const();
        clear_pats();
        st_pat[0] = 1;
        build_exp(40);
        run(40);
        for (int k = 0; k < NN; k++) begin
            int r;
            r = 9 + 8*k;
            n_chk++;
            if (s_rv[r] !== 1'b1 || s_ri[r] !== k || s_rd[r] !== 32'h88000)
                $display("FAIL fixed_res k=%0d got v%0d i%0d %h exp v1 i%0d 88000",
                         k, s_rv[r], s_ri[r], s_rd[r], k);
            else n_pass++;
        end
        for (int t = 0; t < 40; t++) begin
            n_chk++;
            if (s_rv[t] !== e_rv[t] || s_dn[t] !== e_dn[t] ||
                s_bz[t] !== e_bz[t] || s_rd[t] !== e_rd[t])
                $display("FAIL fixed_timeline t=%0d got rv%0d dn%0d bz%0d %h exp rv%0d dn%0d bz%0d %h",
                         t, s_rv[t], s_dn[t], s_bz[t], s_rd[t],
                         e_rv[t], e_dn[t], e_bz[t], e_rd[t]);
            else n_pass++;
        end
    endtask

    task automatic test_relu_clamp();
        fill_const();
        for (int i = 0; i < NI; i++) w_mem[NI+i] = 32'hFFFF0000;
        b_mem[1] = 0;
        clear_pats();
        st_pat[0] = 1;
        run(30);
        n_chk++;
        if (s_rv[17] !== 1'b1 || s_ri[17] !== 1 || s_rd[17] !== 0)
            $display("FAIL relu_clamp got v%0d i%0d %h exp v1 i1 0",
                     s_rv[17], s_ri[17], s_rd[17]);
        else n_pass++;
        n_chk++;
        if (s_rd[9] !== 32'h88000)
            $display("FAIL relu_idx0 got %h exp 88000", s_rd[9]);
        else n_pass++;
    endtask

    task automatic test_addresses();
        fill_rand();
        clear_pats();
        st_pat[0] = 1;
        build_exp(30);
        run(30);
        for (int p = 0; p < NI; p++) begin
            n_chk++;
            if (s_wa[18+p] !== 8 + p || s_ia[18+p] !== p)
                $display("FAIL addr_n2 p=%0d got w%0d i%0d exp w%0d i%0d",
                         p, s_wa[18+p], s_ia[18+p], 8 + p, p);
            else n_pass++;
        end
        n_chk++;
        if (s_ba[17] !== 2)
            $display("FAIL addr_bias got %0d exp 2", s_ba[17]);
        else n_pass++;
        for (int t = 0; t < 30; t++) begin
            n_chk++;
            if (s_ia[t] !== e_ia[t] || s_wa[t] !== e_wa[t] ||
                s_ba[t] !== e_ba[t] || s_bl[t] !== e_bl[t] ||
                s_vl[t] !== e_vl[t])
                $display("FAIL addr_timeline t=%0d got %0d %0d %0d bl%0d v%0d exp %0d %0d %0d bl%0d v%0d",
                         t, s_ia[t], s_wa[t], s_ba[t], s_bl[t], s_vl[t],
                         e_ia[t], e_wa[t], e_ba[t], e_bl[t], e_vl[t]);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        fill_rand();
        clear_pats();
        st_pat[0] = 1;
        st_pat[5] = 1;
        build_exp(40);
        run(40);
        for (int t = 0; t < 40; t++) begin
            n_chk++;
            if (s_rv[t] !== e_rv[t] || s_dn[t] !== e_dn[t] ||
                s_bz[t] !== e_bz[t] || s_ri[t] !== e_ri[t] ||
                s_rd[t] !== e_rd[t])
                $display("FAIL start_ignored t=%0d got rv%0d dn%0d bz%0d i%0d %h exp rv%0d dn%0d bz%0d i%0d %h",
                         t, s_rv[t], s_dn[t], s_bz[t], s_ri[t], s_rd[t],
                         e_rv[t], e_dn[t], e_bz[t], e_ri[t], e_rd[t]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        fill_rand();
        clear_pats();
        for (int t = 0; t < 45; t++) st_pat[t] = 1;
        build_exp(45);
        run(45);
        n_chk++;
        if (s_dn[25] !== 1'b1 || s_bz[25] !== 1'b0 || s_bz[26] !== 1'b1 ||
            s_rv[34] !== 1'b1 || s_ri[34] !== 0)
            $display("FAIL b2b_edges got dn%0d bz%0d bz%0d rv%0d i%0d exp dn1 bz0 bz1 rv1 i0",
                     s_dn[25], s_bz[25], s_bz[26], s_rv[34], s_ri[34]);
        else n_pass++;
        for (int t = 0; t < 45; t++) begin
            n_chk++;
            if (s_rv[t] !== e_rv[t] || s_dn[t] !== e_dn[t] ||
                s_bz[t] !== e_bz[t] || s_bl[t] !== e_bl[t] ||
                s_rd[t] !== e_rd[t])
                $display("FAIL b2b t=%0d got rv%0d dn%0d bz%0d bl%0d %h exp rv%0d dn%0d bz%0d bl%0d %h",
                         t, s_rv[t], s_dn[t], s_bz[t], s_bl[t], s_rd[t],
                         e_rv[t], e_dn[t], e_bz[t], e_bl[t], e_rd[t]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        clear_pats();
        st_pat[0]  = 1;
        rs_pat[12] = 1;
        st_pat[15] = 1;
        build_exp(40);
        run(40);
        n_chk++;
        if (s_bz[13] !== 1'b0 || s_rd[13] !== 0 || s_vl[13] !== 1'b0 ||
            s_rv[24] !== 1'b1 || s_ri[24] !== 0)
            $display("FAIL rst_mid_edges got bz%0d %h v%0d rv%0d i%0d exp bz0 0 v0 rv1 i0",
                     s_bz[13], s_rd[13], s_vl[13], s_rv[24], s_ri[24]);
        else n_pass++;
        for (int t = 0; t < 40; t++) begin
            n_chk++;
            if (s_rv[t] !== e_rv[t] || s_dn[t] !== e_dn[t] ||
                s_bz[t] !== e_bz[t] || s_bl[t] !== e_bl[t] ||
                s_vl[t] !== e_vl[t] || s_ri[t] !== e_ri[t] ||
                s_rd[t] !== e_rd[t] || s_wa[t] !== e_wa[t])
                $display("FAIL rst_mid t=%0d got rv%0d dn%0d bz%0d i%0d %h w%0d exp rv%0d dn%0d bz%0d i%0d %h w%0d",
                         t, s_rv[t], s_dn[t], s_bz[t], s_ri[t], s_rd[t], s_wa[t],
                         e_rv[t], e_dn[t], e_bz[t], e_ri[t], e_rd[t], e_wa[t]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int rep = 0; rep < 3; rep++) begin
            fill_rand();
            clear_pats();
            st_pat[0] = 1;
            build_exp(30);
            run(30);
            for (int k = 0; k < NN; k++) begin
                int r;
                r = (k+1)*P + 1;
                n_chk++;
                if (s_rv[r] !== 1'b1 || s_ri[r] !== k || s_rd[r] !== ref_out(k))
                    $display("FAIL random rep=%0d k=%0d got v%0d i%0d %h exp v1 i%0d %h",
                             rep, k, s_rv[r], s_ri[r], s_rd[r], k, ref_out(k));
                else n_pass++;
            end
        end
    endtask

`ifdef LAYER1_ARGMAX_EN
    task automatic test_argmax();
        for (int c = 0; c < 2; c++) begin
            int ex;
            for (int i = 0; i < NI; i++) in_mem[i] = 32'h20000;
            for (int i = 0; i < NI*NN; i++) w_mem[i] = 0;
            if (c == 0) begin
                b_mem[0] = 32'h30000;
                b_mem[1] = 32'h70000;
                b_mem[2] = 32'h70000;
                ex = 1;
            end else begin
                for (int k = 0; k < NN; k++)
                    b_mem[k] = -int'($urandom_range(1, 65536));
                ex = 0;
            end
            clear_pats();
            st_pat[0] = 1;
            run(30);
            n_chk++;
            if (s_pv[25] !== 1'b1 || s_pi[25] !== ex || s_pi[25] !== ref_argmax())
                $display("FAIL argmax c=%0d got v%0d i%0d exp v1 i%0d",
                         c, s_pv[25], s_pi[25], ex);
            else n_pass++;
            n_chk++;
            if (s_pv[24] !== 1'b0 || s_pv[26] !== 1'b0 || s_pi[28] !== ex)
                $display("FAIL argmax_hold c=%0d got v%0d v%0d i%0d exp v0 v0 i%0d",
                         c, s_pv[24], s_pv[26], s_pi[28], ex);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b0;
        fill_const();
        test_reset();
        test_fixed();
        test_relu_clamp();
        test_addresses();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef LAYER1_ARGMAX_EN
        test_argmax();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
